// File: rtl/burst_seq.sv
// Burst address sequencer: walks INCR/WRAP/FIXED address bursts one beat per
// downstream handshake, with abort and a one-cycle completion pulse.
module burst_seq #(
    parameter int unsigned ADDR_WIDTH    = 8,
    parameter int unsigned COUNTER_WIDTH = 4,
    parameter int unsigned WRAP_BITS     = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic [COUNTER_WIDTH-1:0] burst_len,
    input  logic [ADDR_WIDTH-1:0]    base_addr,
    input  logic [1:0]               mode,
    input  logic                     step_ready,
    output logic                     addr_valid,
    output logic [ADDR_WIDTH-1:0]    addr,
    output logic [COUNTER_WIDTH-1:0] beat_cnt,
    output logic                     last,
    output logic                     busy,
    output logic                     done
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [1:0] ModeWrap  = 2'b01;
    localparam logic [1:0] ModeFixed = 2'b10;

    // Bits that cycle inside the wrap window; the rest of the address is held.
    localparam logic [ADDR_WIDTH-1:0] WrapMask =
        {ADDR_WIDTH{1'b1}} >> (ADDR_WIDTH - WRAP_BITS);

    state_e                   state_q, state_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
    logic [COUNTER_WIDTH-1:0] len_q, len_d;
    logic [1:0]               mode_q, mode_d;
    logic                     valid_q, valid_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;

    logic                     xfer;
    logic                     last_beat;
    logic [ADDR_WIDTH-1:0]    addr_inc;
    logic [ADDR_WIDTH-1:0]    addr_next;

    assign xfer      = valid_q && step_ready;
    assign last_beat = valid_q && (cnt_q == len_q);
    assign addr_inc  = addr_q + 1'b1;

    always_comb begin
        case (mode_q)
            ModeWrap:  addr_next = (addr_q & ~WrapMask) | (addr_inc & WrapMask);
            ModeFixed: addr_next = addr_q;
            default:   addr_next = addr_inc;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        mode_d  = mode_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    state_d = StRun;
                    len_d   = burst_len;
                    mode_d  = mode;
                    addr_d  = base_addr;
                    cnt_d   = '0;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            StRun: begin
                // Abort wins even over a final-beat transfer in the same cycle.
                if (abort) begin
                    state_d = StIdle;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end else if (xfer) begin
                    if (last_beat) begin
                        state_d = StDone;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d  = cnt_q + 1'b1;
                        addr_d = addr_next;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            mode_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            mode_q  <= mode_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign addr_valid = valid_q;
    assign addr       = addr_q;
    assign beat_cnt   = cnt_q;
    assign last       = last_beat;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_burst_seq.sv
// Directed bench for burst_seq: a cycle-by-cycle vector table plus hand-written
// sequences for reset mid-burst and the full-length burst.
module tb_burst_seq;

    localparam int unsigned AW = 8;
    localparam int unsigned CW = 4;
    localparam int unsigned WB = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [CW-1:0] burst_len = '0;
    logic [AW-1:0] base_addr = '0;
    logic [1:0]    mode = '0;
    logic          step_ready = 1'b0;
    logic          addr_valid;
    logic [AW-1:0] addr;
    logic [CW-1:0] beat_cnt;
    logic          last;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    burst_seq #(
        .ADDR_WIDTH   (AW),
        .COUNTER_WIDTH(CW),
        .WRAP_BITS    (WB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .burst_len (burst_len),
        .base_addr (base_addr),
        .mode      (mode),
        .step_ready(step_ready),
        .addr_valid(addr_valid),
        .addr      (addr),
        .beat_cnt  (beat_cnt),
        .last      (last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          st;
        logic          ab;
        logic [CW-1:0] len;
        logic [AW-1:0] base;
        logic [1:0]    md;
        logic          rdy;
        logic          e_valid;
        logic [AW-1:0] e_addr;
        logic [CW-1:0] e_cnt;
        logic          e_last;
        logic          e_busy;
        logic          e_done;
        bit            chk_addr;
        bit            chk_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic st, input logic ab, input logic [CW-1:0] len,
                                input logic [AW-1:0] base, input logic [1:0] md,
                                input logic rdy, input logic v, input logic [AW-1:0] a,
                                input logic [CW-1:0] c, input logic l, input logic b,
                                input logic d, input bit ca, input bit cc);
        vec_t x;
        x.st = st; x.ab = ab; x.len = len; x.base = base; x.md = md; x.rdy = rdy;
        x.e_valid = v; x.e_addr = a; x.e_cnt = c; x.e_last = l; x.e_busy = b;
        x.e_done = d; x.chk_addr = ca; x.chk_cnt = cc;
        vecs.push_back(x);
    endfunction

    initial begin
        // INCR 0x10 len 3 (start on first edge after reset release)
        add(1, 0, 3, 8'h10, 2'b00, 1,  1, 8'h10, 0, 0, 1, 0,  1, 1);
        add(0, 0, 0, 8'h00, 2'b00, 1,  1, 8'h11, 1, 0, 1, 0,  1, 1);
        add(0, 0, 0, 8'h00, 2'b00, 1,  1, 8'h12, 2, 0, 1, 0,  1, 1);
        add(0, 0, 0, 8'h00, 2'b00, 1,  1, 8'h13, 3, 1, 1, 0,  1, 1);
        add(0, 0, 0, 8'h00, 2'b00, 1,  0, 8'h00, 0, 0, 0, 1,  0, 0);
        add(0, 0, 0, 8'h00, 2'b00, 1,  0, 8'h00, 0, 0, 0, 0,  0, 0);
        // WRAP 0x0E len 3
        add(1, 0, 3, 8'h0E, 2'b01, 1,  1, 8'h0E, 0, 0, 1, 0,  1, 1);
        add(0, 0, 0, 8'h00, 2'b00, 1,  1, 8'h0F, 1, 0, 1, 0,  1, 1);
        add(0, 0, 0, 8'h00, 2'b00, 1,  1, 8'h0C, 2, 0, 1, 0,  1, 1);
        add(0, 0, 0, 8'h00, 2'b00, 1,  1, 8'h0D, 3, 1, 1, 0,  1, 1);
        add(0, 0, 0, 8'h00, 2'b00, 1,  0, 8'h00, 0, 0, 0, 1,  0, 0);
        add(0, 0, 0, 8'h00, 2'b00, 0,  0, 8'h00, 0, 0, 0, 0,  0, 0);
        // FIXED 0x55 len 1 with 3 stalled cycles; inputs change mid-burst
        add(1, 0, 1, 8'h55, 2'b10, 0,  1, 8'h55, 0, 0, 1, 0,  1, 1);
        add(0, 0, 7, 8'hAA, 2'b00, 0,  1, 8'h55, 0, 0, 1, 0,  1, 1);
        add(1, 0, 7, 8'hAA, 2'b00, 0,  1, 8'h55, 0, 0, 1, 0,  1, 1);
        add(0, 0, 7, 8'hAA, 2'b00, 0,  1, 8'h55, 0, 0, 1, 0,  1, 1);
        add(0, 0, 7, 8'hAA, 2'b00, 1,  1, 8'h55, 1, 1, 1, 0,  1, 1);
        add(0, 0, 0, 8'h00, 2'b00, 1,  0, 8'h00, 0, 0, 0, 1,  0, 0);
        add(0, 0, 0, 8'h00, 2'b00, 1,  0, 8'h00, 0, 0, 0, 0,  0, 0);
        // Abort at beat 2 of INCR len 7, then immediate len-0 restart
        add(1, 0, 7, 8'h20, 2'b00, 1,  1, 8'h20, 0, 0, 1, 0,  1, 1);
        add(0, 0, 0, 8'h00, 2'b00, 1,  1, 8'h21, 1, 0, 1, 0,  1, 1);
        add(0, 0, 0, 8'h00, 2'b00, 1,  1, 8'h22, 2, 0, 1, 0,  1, 1);
        add(0, 1, 0, 8'h00, 2'b00, 1,  0, 8'h00, 0, 0, 0, 0,  0, 1);
        add(1, 0, 0, 8'h30, 2'b00, 0,  1, 8'h30, 0, 1, 1, 0,  1, 1);
        add(0, 0, 0, 8'h00, 2'b00, 1,  0, 8'h00, 0, 0, 0, 1,  0, 0);
        add(0, 1, 0, 8'h00, 2'b00, 1,  0, 8'h00, 0, 0, 0, 0,  0, 0);
        // Abort coinciding with the final transfer: no done
        add(1, 0, 1, 8'h40, 2'b00, 1,  1, 8'h40, 0, 0, 1, 0,  1, 1);
        add(0, 0, 0, 8'h00, 2'b00, 1,  1, 8'h41, 1, 1, 1, 0,  1, 1);
        add(0, 1, 0, 8'h00, 2'b00, 1,  0, 8'h00, 0, 0, 0, 0,  0, 1);
        add(0, 0, 0, 8'h00, 2'b00, 1,  0, 8'h00, 0, 0, 0, 0,  0, 0);
        // Mode 11 as INCR from 0xFF; start during RUN is ignored
        add(1, 0, 2, 8'hFF, 2'b11, 1,  1, 8'hFF, 0, 0, 1, 0,  1, 1);
        add(1, 0, 5, 8'h80, 2'b10, 1,  1, 8'h00, 1, 0, 1, 0,  1, 1);
        add(1, 0, 5, 8'h80, 2'b10, 1,  1, 8'h01, 2, 1, 1, 0,  1, 1);
        add(1, 0, 5, 8'h80, 2'b10, 1,  0, 8'h00, 0, 0, 0, 1,  0, 0);
        add(0, 0, 0, 8'h00, 2'b00, 1,  0, 8'h00, 0, 0, 0, 0,  0, 0);

        // Reset state, sampled while rst is held low
        repeat (2) @(negedge clk);
        check("rst.valid", 32'(addr_valid), 0);
        check("rst.addr", 32'(addr), 0);
        check("rst.cnt", 32'(beat_cnt), 0);
        check("rst.last", 32'(last), 0);
        check("rst.busy", 32'(busy), 0);
        check("rst.done", 32'(done), 0);
        rst = 1'b1;

        foreach (vecs[i]) begin
            start      = vecs[i].st;
            abort      = vecs[i].ab;
            burst_len  = vecs[i].len;
            base_addr  = vecs[i].base;
            mode       = vecs[i].md;
            step_ready = vecs[i].rdy;
            @(negedge clk);
            check($sformatf("v%0d.valid", i), 32'(addr_valid), 32'(vecs[i].e_valid));
            check($sformatf("v%0d.last", i), 32'(last), 32'(vecs[i].e_last));
            check($sformatf("v%0d.busy", i), 32'(busy), 32'(vecs[i].e_busy));
            check($sformatf("v%0d.done", i), 32'(done), 32'(vecs[i].e_done));
            if (vecs[i].chk_addr)
                check($sformatf("v%0d.addr", i), 32'(addr), 32'(vecs[i].e_addr));
            if (vecs[i].chk_cnt)
                check($sformatf("v%0d.cnt", i), 32'(beat_cnt), 32'(vecs[i].e_cnt));
        end

        // Reset asserted mid-burst forces outputs low between clock edges
        start = 1'b1; abort = 1'b0; burst_len = 4'd5; base_addr = 8'h70; mode = 2'b00;
        step_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("mid.addr_pre", 32'(addr), 32'h71);
        #2 rst = 1'b0;
        #1;
        check("mid.valid", 32'(addr_valid), 0);
        check("mid.addr", 32'(addr), 0);
        check("mid.cnt", 32'(beat_cnt), 0);
        check("mid.last", 32'(last), 0);
        check("mid.busy", 32'(busy), 0);
        check("mid.done", 32'(done), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post.done", 32'(done), 0);
        check("post.valid", 32'(addr_valid), 0);

        // Maximum length: 16 beats, counter reaches 15 without overflow
        start = 1'b1; burst_len = 4'hF; base_addr = 8'hF8; mode = 2'b00;
        @(negedge clk);
        start = 1'b0;
        for (int b = 0; b < 16; b++) begin
            check($sformatf("max%0d.addr", b), 32'(addr), 32'((8'hF8 + b) & 8'hFF));
            check($sformatf("max%0d.cnt", b), 32'(beat_cnt), 32'(b));
            check($sformatf("max%0d.last", b), 32'(last), 32'(b == 15));
            @(negedge clk);
        end
        check("max.done", 32'(done), 1);
        check("max.busy", 32'(busy), 0);
        @(negedge clk);
        check("max.done_off", 32'(done), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
